// File: rtl/mem_pkg.sv
// Shared encodings and lane helpers for the data-memory access controller.
package mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b01;
    localparam logic [1:0] SZ_HALF = 2'b10;
    localparam logic [1:0] SZ_WORD = 2'b00;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    // Encoding 2'b11 is treated as a word, same as SZ_WORD.
    function automatic logic [3:0] byte_enables(input logic [1:0] size,
                                                input logic [1:0] offset);
        case (size)
            SZ_BYTE: byte_enables = 4'b0001 << offset;
            SZ_HALF: byte_enables = offset[1] ? 4'b1100 : 4'b0011;
            default: byte_enables = 4'b1111;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [1:0] offset);
        case (size)
            SZ_BYTE: is_misaligned = 1'b0;
            SZ_HALF: is_misaligned = offset[0];
            default: is_misaligned = |offset;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian lane steering: store replication, byte enables, load extraction and extension.
module mem_lane_align
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [1:0]            size,
    input  logic [1:0]            offset,
    input  logic                  is_signed,
    input  logic [DATA_WIDTH-1:0] store_data,
    input  logic [DATA_WIDTH-1:0] load_word,
    output logic [3:0]            byteen,
    output logic [DATA_WIDTH-1:0] write_data,
    output logic [DATA_WIDTH-1:0] load_data
);

    logic [7:0]         lane_byte;
    logic [15:0]        lane_half;
    logic signed [7:0]  lane_byte_s;
    logic signed [15:0] lane_half_s;

    always_comb begin
        byteen      = byte_enables(size, offset);
        lane_byte   = load_word[{offset, 3'b000} +: 8];
        lane_half   = offset[1] ? load_word[31:16] : load_word[15:0];
        lane_byte_s = lane_byte;
        lane_half_s = lane_half;
        case (size)
            SZ_BYTE: begin
                write_data = DATA_WIDTH'({4{store_data[7:0]}});
                load_data  = is_signed ? DATA_WIDTH'(lane_byte_s) : DATA_WIDTH'(lane_byte);
            end
            SZ_HALF: begin
                write_data = DATA_WIDTH'({2{store_data[15:0]}});
                load_data  = is_signed ? DATA_WIDTH'(lane_half_s) : DATA_WIDTH'(lane_half);
            end
            default: begin
                write_data = store_data;
                load_data  = load_word;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Multi-cycle load/store controller: latches one request, holds memory strobes for
// WAIT_CYCLES cycles while stalling the pipeline, then pulses o_valid with the load result.
module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_valid,
    input  logic [DATA_WIDTH-1:0] i_address,
    input  logic [DATA_WIDTH-1:0] i_datawrite,
    input  logic                  i_memread,
    input  logic                  i_memwrite,
    input  logic                  i_signed,
    input  logic [1:0]            i_size,
    input  logic [DATA_WIDTH-1:0] i_mem_dataread,
    output logic [DATA_WIDTH-1:0] o_mem_address,
    output logic [DATA_WIDTH-1:0] o_mem_datawrite,
    output logic [3:0]            o_mem_byteen,
    output logic                  o_mem_read,
    output logic                  o_mem_write,
    output logic                  o_stall,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_dataread,
    output logic                  o_misaligned
);

    state_t                state, state_next;
    logic [3:0]            count, count_next;
    logic                  accept;
    logic                  misaligned_in;
    logic                  in_access;
    logic [DATA_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [1:0]            size_q;
    logic                  signed_q;
    logic                  write_q;
    logic [3:0]            lane_byteen;
    logic [DATA_WIDTH-1:0] lane_wdata;
    logic [DATA_WIDTH-1:0] lane_rdata;

    assign accept        = i_valid && (i_memread || i_memwrite);
    assign misaligned_in = is_misaligned(i_size, i_address[1:0]);
    assign in_access     = (state == ACCESS);

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state <= IDLE;
            count <= 4'd0;
        end else begin
            state <= state_next;
            count <= count_next;
        end
    end

    always_comb begin
        state_next = state;
        count_next = count;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (misaligned_in) begin
                        state_next = DONE;
                    end else begin
                        state_next = ACCESS;
                        count_next = 4'(WAIT_CYCLES - 1);
                    end
                end
            end
            ACCESS: begin
                if (count == 4'd0) begin
                    state_next = DONE;
                end else begin
                    count_next = count - 4'd1;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Request fields are only observed while in ACCESS, so they need no reset.
    always_ff @(posedge i_clock) begin
        if (state == IDLE && accept) begin
            addr_q   <= i_address;
            data_q   <= i_datawrite;
            size_q   <= i_size;
            signed_q <= i_signed;
            write_q  <= i_memwrite;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            o_dataread   <= '0;
            o_misaligned <= 1'b0;
        end else if (state == IDLE && accept && misaligned_in) begin
            o_dataread   <= '0;
            o_misaligned <= 1'b1;
        end else if (in_access && count == 4'd0) begin
            o_dataread   <= write_q ? '0 : lane_rdata;
            o_misaligned <= 1'b0;
        end
    end

    mem_lane_align #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_lane_align (
        .size      (size_q),
        .offset    (addr_q[1:0]),
        .is_signed (signed_q),
        .store_data(data_q),
        .load_word (i_mem_dataread),
        .byteen    (lane_byteen),
        .write_data(lane_wdata),
        .load_data (lane_rdata)
    );

    // Memory-side outputs are forced to zero outside ACCESS so a reset clears them at once.
    always_comb begin
        o_mem_address   = in_access ? {2'b00, addr_q[DATA_WIDTH-1:2]} : '0;
        o_mem_datawrite = in_access ? lane_wdata : '0;
        o_mem_byteen    = in_access ? lane_byteen : 4'b0000;
        o_mem_read      = in_access && !write_q;
        o_mem_write     = in_access && write_q;
        o_stall         = (state == IDLE && accept) || in_access;
        o_valid         = (state == DONE);
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: two instances (WAIT_CYCLES 1 and 3), directed table, corner sequences, random vs model.
module tb_mem_access_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic [1:0]       valid, rd, wr, sg, mrd, mwr, stall, ovalid, mis;
    logic [1:0][1:0]  sz;
    logic [1:0][31:0] addr, d, mw, maddr, mwdata, rdata;
    logic [1:0][3:0]  be;

    int total = 0;
    int bad   = 0;
    logic [31:0] last_rdata [2];

    typedef struct {
        int          k;
        logic [31:0] addr;
        logic [31:0] d;
        logic [31:0] mw;
        logic        rd;
        logic        wr;
        logic        sg;
        logic [1:0]  sz;
        logic [31:0] x_maddr;
        logic [3:0]  x_be;
        logic [31:0] x_wdata;
        logic [31:0] x_rdata;
        logic        x_mis;
    } vec_t;

    mem_access_ctrl #(.DATA_WIDTH(32), .WAIT_CYCLES(1)) u_w1 (
        .i_clock(clk), .i_reset(rst), .i_valid(valid[0]), .i_address(addr[0]),
        .i_datawrite(d[0]), .i_memread(rd[0]), .i_memwrite(wr[0]), .i_signed(sg[0]),
        .i_size(sz[0]), .i_mem_dataread(mw[0]), .o_mem_address(maddr[0]),
        .o_mem_datawrite(mwdata[0]), .o_mem_byteen(be[0]), .o_mem_read(mrd[0]),
        .o_mem_write(mwr[0]), .o_stall(stall[0]), .o_valid(ovalid[0]),
        .o_dataread(rdata[0]), .o_misaligned(mis[0])
    );

    mem_access_ctrl #(.DATA_WIDTH(32), .WAIT_CYCLES(3)) u_w3 (
        .i_clock(clk), .i_reset(rst), .i_valid(valid[1]), .i_address(addr[1]),
        .i_datawrite(d[1]), .i_memread(rd[1]), .i_memwrite(wr[1]), .i_signed(sg[1]),
        .i_size(sz[1]), .i_mem_dataread(mw[1]), .o_mem_address(maddr[1]),
        .o_mem_datawrite(mwdata[1]), .o_mem_byteen(be[1]), .o_mem_read(mrd[1]),
        .o_mem_write(mwr[1]), .o_stall(stall[1]), .o_valid(ovalid[1]),
        .o_dataread(rdata[1]), .o_misaligned(mis[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    // Reference model: derives lane behaviour from access width in bytes and byte offset.
    function automatic vec_t model(input int k, input logic [31:0] a, input logic [31:0] dd,
                                   input logic [31:0] m, input logic r, input logic w,
                                   input logic s, input logic [1:0] z);
        vec_t v;
        int nb;
        int off;
        logic [63:0] val;
        v.k = k; v.addr = a; v.d = dd; v.mw = m; v.rd = r; v.wr = w; v.sg = s; v.sz = z;
        nb  = (z == 2'b01) ? 1 : (z == 2'b10) ? 2 : 4;
        off = int'(a % 4);
        v.x_mis   = (int'(a % 256) % nb) != 0;
        v.x_maddr = a / 4;
        v.x_be    = 4'(((1 << nb) - 1) << off);
        for (int i = 0; i < 4; i++) v.x_wdata[8*i +: 8] = dd[8*(i % nb) +: 8];
        v.x_rdata = 32'h0;
        if (!w && !v.x_mis) begin
            val = {32'h0, m} >> (8 * off);
            val = val & ((64'd1 << (8 * nb)) - 64'd1);
            if (s && nb < 4 && val[8*nb-1]) val = val - (64'd1 << (8 * nb));
            v.x_rdata = val[31:0];
        end
        return v;
    endfunction

    // Called at a falling edge; presents the request and follows it to completion.
    task automatic run(input vec_t v, input string tag);
        int k;
        int lat;
        k   = v.k;
        lat = v.x_mis ? 1 : (((k == 0) ? 1 : 3) + 1);
        valid[k] = 1'b1; addr[k] = v.addr; d[k] = v.d; mw[k] = v.mw;
        rd[k] = v.rd; wr[k] = v.wr; sg[k] = v.sg; sz[k] = v.sz;
        #1;
        chk({tag, ".stall_accept"}, stall[k], 1);
        chk({tag, ".strobe_accept"}, {mrd[k], mwr[k]}, 0);
        chk({tag, ".valid_accept"}, ovalid[k], 0);
        for (int c = 1; c <= lat; c++) begin
            @(negedge clk);
            if (c < lat) begin
                chk({tag, ".stall_access"}, stall[k], 1);
                chk({tag, ".valid_access"}, ovalid[k], 0);
                chk({tag, ".mem_read"}, mrd[k], !v.wr);
                chk({tag, ".mem_write"}, mwr[k], v.wr);
                chk({tag, ".mem_address"}, maddr[k], v.x_maddr);
                chk({tag, ".byteen"}, be[k], v.x_be);
                if (v.wr) chk({tag, ".datawrite"}, mwdata[k], v.x_wdata);
            end else begin
                chk({tag, ".valid_done"}, ovalid[k], 1);
                chk({tag, ".stall_done"}, stall[k], 0);
                chk({tag, ".strobe_done"}, {mrd[k], mwr[k]}, 0);
                chk({tag, ".dataread"}, rdata[k], v.x_rdata);
                chk({tag, ".misaligned"}, mis[k], v.x_mis);
                valid[k] = 1'b0;
            end
        end
        @(negedge clk);
        chk({tag, ".valid_after"}, ovalid[k], 0);
        chk({tag, ".dataread_hold"}, rdata[k], v.x_rdata);
        last_rdata[k] = v.x_rdata;
    endtask

    vec_t tbl [11];
    vec_t rv;

    initial begin
        // k, addr, d, mw, rd, wr, sg, sz, maddr, be, wdata, rdata, mis
        tbl[0]  = '{0, 32'h13, 32'h0,        32'h80FF7F01, 1'b1, 1'b0, 1'b1, 2'b01, 32'h4, 4'b1000, 32'h0,        32'hFFFFFF80, 1'b0};
        tbl[1]  = '{0, 32'h22, 32'h0000BEEF, 32'h0,        1'b0, 1'b1, 1'b0, 2'b10, 32'h8, 4'b1100, 32'hBEEFBEEF, 32'h0,        1'b0};
        tbl[2]  = '{0, 32'h06, 32'h0,        32'h0,        1'b1, 1'b0, 1'b0, 2'b00, 32'h0, 4'b0000, 32'h0,        32'h0,        1'b1};
        tbl[3]  = '{1, 32'h2C, 32'hDEADBEEF, 32'h0,        1'b0, 1'b1, 1'b0, 2'b00, 32'hB, 4'b1111, 32'hDEADBEEF, 32'h0,        1'b0};
        tbl[4]  = '{1, 32'h05, 32'h00001111, 32'h0,        1'b0, 1'b1, 1'b0, 2'b10, 32'h0, 4'b0000, 32'h0,        32'h0,        1'b1};
        tbl[5]  = '{1, 32'h00, 32'h0,        32'h1234F00D, 1'b1, 1'b0, 1'b0, 2'b10, 32'h0, 4'b0011, 32'h0,        32'h0000F00D, 1'b0};
        tbl[6]  = '{0, 32'h10, 32'hA5A55A5A, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b0, 2'b00, 32'h4, 4'b1111, 32'hA5A55A5A, 32'h0,        1'b0};
        tbl[7]  = '{0, 32'h02, 32'h0,        32'h80017FFF, 1'b1, 1'b0, 1'b1, 2'b10, 32'h0, 4'b1100, 32'h0,        32'hFFFF8001, 1'b0};
        tbl[8]  = '{0, 32'h01, 32'h0,        32'h00009A00, 1'b1, 1'b0, 1'b0, 2'b01, 32'h0, 4'b0010, 32'h0,        32'h0000009A, 1'b0};
        tbl[9]  = '{0, 32'h02, 32'h123456C3, 32'h0,        1'b0, 1'b1, 1'b0, 2'b01, 32'h0, 4'b0100, 32'hC3C3C3C3, 32'h0,        1'b0};
        tbl[10] = '{0, 32'h08, 32'h0,        32'h80000001, 1'b1, 1'b0, 1'b1, 2'b11, 32'h2, 4'b1111, 32'h0,        32'h80000001, 1'b0};

        rst = 1'b1;
        valid = '0; rd = '0; wr = '0; sg = '0; sz = '0; addr = '0; d = '0; mw = '0;
        last_rdata[0] = 32'h0;
        last_rdata[1] = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("reset.mem_address", maddr[k], 0);
            chk("reset.datawrite", mwdata[k], 0);
            chk("reset.byteen", be[k], 0);
            chk("reset.strobes", {mrd[k], mwr[k]}, 0);
            chk("reset.valid", ovalid[k], 0);
            chk("reset.stall", stall[k], 0);
            chk("reset.misaligned", mis[k], 0);
            chk("reset.dataread", rdata[k], 0);
        end
        rst = 1'b0;

        for (int i = 0; i < 11; i++) run(tbl[i], $sformatf("vec%0d", i));

        // Non-memory instruction: no stall, no completion, result registers untouched.
        valid[0] = 1'b1; rd[0] = 1'b0; wr[0] = 1'b0;
        #1;
        chk("nonmem.stall_now", stall[0], 0);
        repeat (3) begin
            @(negedge clk);
            chk("nonmem.valid", ovalid[0], 0);
            chk("nonmem.stall", stall[0], 0);
            chk("nonmem.strobes", {mrd[0], mwr[0]}, 0);
            chk("nonmem.dataread_hold", rdata[0], last_rdata[0]);
        end
        valid[0] = 1'b0;

        // Reset landing in the second ACCESS cycle of a WAIT_CYCLES=3 load.
        valid[1] = 1'b1; rd[1] = 1'b1; wr[1] = 1'b0; sg[1] = 1'b0; sz[1] = 2'b00;
        addr[1] = 32'h40; mw[1] = 32'hCAFEBABE; d[1] = 32'h0;
        @(negedge clk);
        chk("rstmid.read_a1", mrd[1], 1);
        @(negedge clk);
        chk("rstmid.read_a2", mrd[1], 1);
        chk("rstmid.stall_a2", stall[1], 1);
        rst = 1'b1;
        valid[1] = 1'b0;
        @(negedge clk);
        chk("rstmid.strobes", {mrd[1], mwr[1]}, 0);
        chk("rstmid.byteen", be[1], 0);
        chk("rstmid.mem_address", maddr[1], 0);
        chk("rstmid.datawrite", mwdata[1], 0);
        chk("rstmid.valid", ovalid[1], 0);
        chk("rstmid.stall", stall[1], 0);
        chk("rstmid.misaligned", mis[1], 0);
        chk("rstmid.dataread", rdata[1], 0);
        rst = 1'b0;
        last_rdata[0] = 32'h0;
        repeat (5) begin
            @(negedge clk);
            chk("rstmid.no_valid", ovalid[1], 0);
            chk("rstmid.no_read", mrd[1], 0);
        end
        rv = '{1, 32'h40, 32'h0, 32'hCAFEBABE, 1'b1, 1'b0, 1'b0, 2'b00,
               32'h10, 4'b1111, 32'h0, 32'hCAFEBABE, 1'b0};
        run(rv, "rstmid.followup");

        // Randomized requests on both instances against the model.
        for (int i = 0; i < 60; i++) begin
            logic r, w;
            r = 1'($urandom_range(0, 1));
            w = 1'($urandom_range(0, 1));
            if (!r && !w) r = 1'b1;
            rv = model(i % 2, 32'($urandom_range(0, 255)), $urandom, $urandom, r, w,
                       1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
            run(rv, $sformatf("rand%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Multi-cycle load/store controller between the EX/MEM pipeline register and the data memory. It latches one memory request, checks alignment, converts the byte address into a word index plus byte enables, and drives the memory strobes for a fixed number of wait cycles while stalling the pipeline. It then returns the extracted, sign- or zero-extended load data to the MEM/WB register. It is the only block that drives the data memory's address, data and strobe inputs.

## Interface
- DATA_WIDTH, 32: data and byte-address width.
- WAIT_CYCLES, 1: number of cycles the memory strobes are held per access; legal range 1..15.
- i_clock  in  1  rising-edge clock.
- i_reset  in  1  synchronous, active-high reset.
- i_valid  in  1  EX/MEM slot holds a live instruction.
- i_address  in  DATA_WIDTH  byte address from the ALU.
- i_datawrite  in  DATA_WIDTH  store data, right-justified.
- i_memread / i_memwrite  in  1 each  load / store request.
- i_signed  in  1  sign-extend loads.
- i_size  in  2  01 = byte, 10 = halfword, 00 or 11 = word.
- i_mem_dataread  in  DATA_WIDTH  raw word from memory.
- o_mem_address  out  DATA_WIDTH  word index, {2'b0, addr[DATA_WIDTH-1:2]}.
- o_mem_datawrite  out  DATA_WIDTH  lane-replicated store data.
- o_mem_byteen  out  4  byte-lane enables; bit n covers bits [8n+7:8n].
- o_mem_read / o_mem_write  out  1 each  memory strobes.
- o_stall  out  1  freeze IF/ID/EX and the EX/MEM register.
- o_valid  out  1  one-cycle pulse: result ready for MEM/WB.
- o_dataread  out  DATA_WIDTH  aligned and extended load result.
- o_misaligned  out  1  valid with o_valid: request was misaligned.

## Operation
- States: IDLE, ACCESS, DONE.
- IDLE:
  - Accept when i_valid && (i_memread || i_memwrite).
  - On accept, latch address, data, size, signed and op.
  - Op is write if i_memwrite, else read. When both are set, write wins and o_dataread is 0.
- Misalignment: halfword with addr[0]=1, or word with addr[1:0]≠0.
  - Go IDLE→DONE with o_misaligned=1 and o_dataread=0.
  - No memory strobe is ever raised.
- Aligned request: IDLE→ACCESS with the counter loaded to WAIT_CYCLES-1.
- ACCESS:
  - o_mem_read or o_mem_write held high; address, data and byte enables stable.
  - Counter decrements each cycle.
  - In the cycle the counter is 0: sample i_mem_dataread into a register, then go to DONE.
- DONE: o_valid=1 for one cycle, then go to IDLE. i_valid is ignored in DONE, because the slot still holds the finished instruction.
- Lane mapping is little-endian.
  - Byte: byteen = 1<<addr[1:0]; datawrite = {4{d[7:0]}}.
  - Half: byteen = addr[1] ? 1100 : 0011; datawrite = {2{d[15:0]}}.
  - Word: byteen = 1111.
- Loads:
  - Byte: extract byte lane addr[1:0]. Half: extract half lane addr[1].
  - Sign-extend if i_signed, else zero-extend. Word loads ignore i_signed.
- Stores produce o_dataread=0.

## Timing
- o_stall = (IDLE && accept) || ACCESS. It is combinational from i_valid, i_memread and i_memwrite in IDLE, and is low in DONE.
- Aligned access latency: accept cycle T, ACCESS for T+1..T+WAIT_CYCLES, o_valid at T+WAIT_CYCLES+1.
- Misaligned access: o_valid at T+1.
- o_dataread and o_misaligned are registered. They hold their value until the next DONE.
- Non-memory instruction (i_valid with no memread/memwrite): no stall, no o_valid, no state change.
- Reset, including mid-ACCESS: after the clock edge, state=IDLE, all strobes 0, o_mem_byteen=0, o_mem_address=0, o_mem_datawrite=0, o_valid=0, o_misaligned=0, o_dataread=0, o_stall=0 (unless an accept is pending). The aborted access produces no o_valid.

## Structure
- Package mem_pkg:
  - Size encodings SZ_BYTE=2'b01, SZ_HALF=2'b10, SZ_WORD=2'b00.
  - State enum {IDLE, ACCESS, DONE}.
  - Function for byte enables by size and offset.
- Sub-module mem_lane_align: combinational store replication and byte enables, plus load extraction and extension. The FSM, counter and registers stay in the top module.

## Test plan
- Signed byte load, addr=0x13, mem word 0x80FF7F01, WAIT_CYCLES=1 -> o_mem_address=0x4, o_mem_read for 1 cycle, o_dataread=0xFFFFFF80, o_valid at T+2, o_stall high at T and T+1.
- Halfword store, addr=0x22, d=0x0000BEEF -> o_mem_address=0x8, byteen=1100, datawrite=0xBEEFBEEF, o_mem_write for 1 cycle.
- Misaligned word load, addr=0x06 -> no strobes, o_valid and o_misaligned at T+1, o_dataread=0.
- WAIT_CYCLES=3, unsigned half load, addr=0x0, mem word 0x1234F00D -> strobe held 3 cycles, o_dataread=0x0000F00D at T+4.
- Reset asserted in the second ACCESS cycle (WAIT_CYCLES=3) -> next cycle all strobes 0, no o_valid; a follow-up word load of 0xCAFEBABE completes normally.
- memread and memwrite both set, plus a non-memory instruction -> treated as a write with o_dataread=0; the non-memory instruction gives no stall and no o_valid.
